// File: rtl/bus_arbiter.sv
// bus_arbiter: four-master round-robin bus arbiter with a begin-wait timeout and a busy watchdog
module bus_arbiter #(
  parameter int timeoutCycles = 1024,
  parameter int beginWaitCycles = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] busRequests,
  input  logic       beginTransactionIn,
  input  logic       endTransactionIn,
  output logic [3:0] busGrants,
  output logic [1:0] activeMaster,
  output logic       busActive,
  output logic       busErrorOut,
  output logic       endTransactionOut
);
  typedef enum logic [2:0] {IDLE, WAIT_BEGIN, BUSY, ERROR, END} arbState;
  arbState state, nextState;
  logic [1:0] lastGrant, winner;
  logic [7:0] waitCounter;
  logic [15:0] watchdog;
  logic waitDone, timedOut, granting;
  assign waitDone = waitCounter == 8'(beginWaitCycles - 1);
  assign timedOut = watchdog == 16'(timeoutCycles - 1);
  assign granting = state == IDLE && |busRequests;
  // Scan downward so the nearest index after lastGrant is assigned last and wins.
  always_comb begin
    winner = lastGrant;
    for (int k = 4; k >= 1; k--)
      if (busRequests[2'(lastGrant + 2'(k))]) winner = 2'(lastGrant + 2'(k));
  end
  always_comb begin
    nextState = state;
    case (state)
      IDLE:       nextState = |busRequests ? WAIT_BEGIN : IDLE;
      WAIT_BEGIN: nextState = beginTransactionIn ? BUSY : waitDone ? IDLE : WAIT_BEGIN;
      BUSY:       nextState = endTransactionIn ? IDLE : timedOut ? ERROR : BUSY;
      ERROR:      nextState = END;
      default:    nextState = IDLE;
    endcase
  end
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state <= IDLE;
      busGrants <= '0;
      activeMaster <= 2'd0;
      lastGrant <= 2'd3;
      busActive <= 1'b0;
      busErrorOut <= 1'b0;
      endTransactionOut <= 1'b0;
      waitCounter <= '0;
      watchdog <= '0;
    end else begin
      state <= nextState;
      busGrants <= granting ? 4'b0001 << winner : 4'b0000;
      activeMaster <= granting ? winner : activeMaster;
      lastGrant <= granting ? winner : lastGrant;
      busActive <= nextState != IDLE;
      busErrorOut <= nextState == ERROR;
      endTransactionOut <= nextState == END;
      waitCounter <= state == WAIT_BEGIN ? waitCounter + 8'd1 : '0;
      watchdog <= state != BUSY ? '0 : timedOut ? watchdog : watchdog + 16'd1;
    end
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed-vector bench for bus_arbiter with a 16-cycle watchdog
module tb_bus_arbiter;
  logic clock = 1'b0;
  logic reset = 1'b0;
  logic [3:0] busRequests = '0;
  logic beginTransactionIn = 1'b0;
  logic endTransactionIn = 1'b0;
  logic [3:0] busGrants;
  logic [1:0] activeMaster;
  logic busActive, busErrorOut, endTransactionOut;
  int vectors = 0;
  int miscompares = 0;

  bus_arbiter #(.timeoutCycles(16), .beginWaitCycles(8)) dut (
    .clock(clock), .reset(reset), .busRequests(busRequests),
    .beginTransactionIn(beginTransactionIn), .endTransactionIn(endTransactionIn),
    .busGrants(busGrants), .activeMaster(activeMaster), .busActive(busActive),
    .busErrorOut(busErrorOut), .endTransactionOut(endTransactionOut)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic checkIdleOutputs(input string tag);
    check({tag, " grants"}, 32'(busGrants), 0);
    check({tag, " active"}, 32'(busActive), 0);
    check({tag, " error"}, 32'(busErrorOut), 0);
    check({tag, " endOut"}, 32'(endTransactionOut), 0);
  endtask

  // Grant, begin the next cycle, end five cycles after begin.
  task automatic transaction(input int master);
    tick;
    check($sformatf("rr grant m%0d", master), 32'(busGrants), 32'(4'b0001 << master));
    check($sformatf("rr master m%0d", master), 32'(activeMaster), 32'(master));
    beginTransactionIn = 1'b1;
    tick;
    beginTransactionIn = 1'b0;
    check("rr grant pulse", 32'(busGrants), 0);
    check("rr busy active", 32'(busActive), 1);
    repeat (4) tick;
    endTransactionIn = 1'b1;
    tick;
    endTransactionIn = 1'b0;
    check("rr end idle", 32'(busActive), 0);
  endtask

  initial begin
    #12;
    checkIdleOutputs("reset");
    check("reset master", 32'(activeMaster), 0);
    tick;
    reset = 1'b1;
    tick;
    check("idle no req", 32'(busGrants), 0);
    busRequests = 4'b1111;
    for (int i = 0; i < 5; i++) transaction(i % 4);
    busRequests = 4'b0000;
    tick;
    checkIdleOutputs("idle hold");
    check("master hold", 32'(activeMaster), 0);

    busRequests = 4'b0100;
    tick;
    busRequests = 4'b0000;
    check("s2 grant", 32'(busGrants), 32'(4'b0100));
    check("s2 master", 32'(activeMaster), 2);
    check("s2 active", 32'(busActive), 1);
    endTransactionIn = 1'b1;
    tick;
    endTransactionIn = 1'b0;
    check("s2 grant pulse", 32'(busGrants), 0);
    check("s3 end ignored", 32'(busActive), 1);
    repeat (6) tick;
    check("s3 still waiting", 32'(busActive), 1);
    tick;
    checkIdleOutputs("s3 timeout");
    busRequests = 4'b0001;
    tick;
    busRequests = 4'b0000;
    check("s3 next grant", 32'(busGrants), 32'(4'b0001));
    check("s3 next master", 32'(activeMaster), 0);

    beginTransactionIn = 1'b1;
    tick;
    beginTransactionIn = 1'b0;
    repeat (15) tick;
    check("s4 no early error", 32'(busErrorOut), 0);
    tick;
    check("s4 error", 32'(busErrorOut), 1);
    check("s4 no endOut yet", 32'(endTransactionOut), 0);
    check("s4 active err", 32'(busActive), 1);
    tick;
    check("s4 error pulse", 32'(busErrorOut), 0);
    check("s4 endOut", 32'(endTransactionOut), 1);
    tick;
    checkIdleOutputs("s4 idle");

    busRequests = 4'b1000;
    tick;
    busRequests = 4'b0000;
    check("s5 grant", 32'(busGrants), 32'(4'b1000));
    check("s5 master", 32'(activeMaster), 3);
    beginTransactionIn = 1'b1;
    tick;
    beginTransactionIn = 1'b0;
    repeat (15) tick;
    endTransactionIn = 1'b1;
    tick;
    endTransactionIn = 1'b0;
    checkIdleOutputs("s5 end wins");
    tick;
    checkIdleOutputs("s5 after");

    busRequests = 4'b1000;
    tick;
    busRequests = 4'b0000;
    check("s6 grant", 32'(busGrants), 32'(4'b1000));
    beginTransactionIn = 1'b1;
    tick;
    beginTransactionIn = 1'b0;
    repeat (3) tick;
    #2 reset = 1'b0;
    #1;
    checkIdleOutputs("s6 async reset");
    check("s6 reset master", 32'(activeMaster), 0);
    tick;
    reset = 1'b1;
    busRequests = 4'b1001;
    tick;
    busRequests = 4'b0000;
    check("s6 m0 priority", 32'(busGrants), 32'(4'b0001));
    check("s6 m0 master", 32'(activeMaster), 0);
    tick;
    check("s6 no stray pulses", 32'({busErrorOut, endTransactionOut}), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
